// File: rtl/bus_req_port.sv
// Single-outstanding request port between a core and the bus arbiter.
// It latches one core request, handshakes it through the arbiter and guards it with a timeout.
module bus_req_port #(
  parameter int unsigned TMO_W = 12
) (
  input  logic        CLK,
  input  logic        RST_X,
  // core side
  input  logic        core_dram_le,
  input  logic        core_dram_we_t,
  input  logic        core_data_le,
  input  logic        core_data_we,
  input  logic [31:0] core_dram_addr,
  input  logic [31:0] core_dram_wdata,
  input  logic [2:0]  core_dram_ctrl,
  input  logic [31:0] core_mem_paddr,
  input  logic [31:0] core_data_wdata,
  output logic        core_busy,
  output logic        core_done,
  output logic [31:0] core_dram_odata,
  output logic [31:0] core_data_data,
  // arbiter side
  output logic        arb_req,
  input  logic        arb_gnt,
  output logic        arb_dram_le,
  output logic        arb_dram_we_t,
  output logic        arb_data_le,
  output logic        arb_data_we,
  output logic [31:0] arb_dram_addr,
  output logic [31:0] arb_dram_wdata,
  output logic [2:0]  arb_dram_ctrl,
  output logic [31:0] arb_mem_paddr,
  output logic [31:0] arb_data_wdata,
  input  logic        arb_sys_busy,
  input  logic [31:0] arb_dram_odata,
  input  logic [31:0] arb_data_data,
  // status
  output logic        err_timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StIssue, StWaitDone} state_e;

  localparam logic [TMO_W-1:0] TmoMax = '1;

  state_e            state_q, state_d;
  logic [3:0]        lat_q, lat_d;    // {dram_le, dram_we_t, data_le, data_we}
  logic [3:0]        strb_q, strb_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [TMO_W-1:0]  tmo_inc;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              req_q, req_d;
  logic              err_q, err_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [31:0]       paddr_q, paddr_d;
  logic [31:0]       dwdata_q, dwdata_d;
  logic [31:0]       dram_odata_q, dram_odata_d;
  logic [31:0]       data_data_q, data_data_d;
  logic [3:0]        core_strb;

  assign core_strb = {core_dram_le, core_dram_we_t, core_data_le, core_data_we};
  assign tmo_inc   = (tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    strb_d       = strb_q;
    tmo_d        = tmo_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    req_d        = req_q;
    err_d        = err_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ctrl_d       = ctrl_q;
    paddr_d      = paddr_q;
    dwdata_d     = dwdata_q;
    dram_odata_d = dram_odata_q;
    data_data_d  = data_data_q;

    case (state_q)
      StIdle: begin
        if (|core_strb) begin
          lat_d    = core_strb;
          addr_d   = core_dram_addr;
          wdata_d  = core_dram_wdata;
          ctrl_d   = core_dram_ctrl;
          paddr_d  = core_mem_paddr;
          dwdata_d = core_data_wdata;
          busy_d   = 1'b1;
          req_d    = 1'b1;
          state_d  = StReq;
        end
      end
      StReq: begin
        // No timeout here: the arbiter may legitimately starve this port.
        if (arb_gnt) begin
          strb_d  = lat_q;
          tmo_d   = '0;
          state_d = StIssue;
        end
      end
      StIssue, StWaitDone: begin
        tmo_d = tmo_inc;
        if (tmo_inc == TmoMax) begin
          err_d        = 1'b1;
          strb_d       = '0;
          req_d        = 1'b0;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          dram_odata_d = '0;
          data_data_d  = '0;
          state_d      = StIdle;
        end else if (state_q == StIssue) begin
          if (arb_sys_busy) begin
            strb_d  = '0;
            state_d = StWaitDone;
          end
        end else if (!arb_sys_busy) begin
          // Captured for writes too; the core ignores it in that case.
          dram_odata_d = arb_dram_odata;
          data_data_d  = arb_data_data;
          busy_d       = 1'b0;
          req_d        = 1'b0;
          done_d       = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q      <= StIdle;
      lat_q        <= '0;
      strb_q       <= '0;
      tmo_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      req_q        <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ctrl_q       <= '0;
      paddr_q      <= '0;
      dwdata_q     <= '0;
      dram_odata_q <= '0;
      data_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      strb_q       <= strb_d;
      tmo_q        <= tmo_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      req_q        <= req_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ctrl_q       <= ctrl_d;
      paddr_q      <= paddr_d;
      dwdata_q     <= dwdata_d;
      dram_odata_q <= dram_odata_d;
      data_data_q  <= data_data_d;
    end
  end

  assign core_busy       = busy_q;
  assign core_done       = done_q;
  assign core_dram_odata = dram_odata_q;
  assign core_data_data  = data_data_q;
  assign arb_req         = req_q;
  assign arb_dram_le     = strb_q[3];
  assign arb_dram_we_t   = strb_q[2];
  assign arb_data_le     = strb_q[1];
  assign arb_data_we     = strb_q[0];
  assign arb_dram_addr   = addr_q;
  assign arb_dram_wdata  = wdata_q;
  assign arb_dram_ctrl   = ctrl_q;
  assign arb_mem_paddr   = paddr_q;
  assign arb_data_wdata  = dwdata_q;
  assign err_timeout     = err_q;

endmodule

// File: tb/tb_bus_req_port.sv
// Directed bench for bus_req_port: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever core_done is seen.
module tb_bus_req_port;

  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic        core_dram_le = 1'b0, core_dram_we_t = 1'b0, core_data_le = 1'b0;
  logic        core_data_we = 1'b0;
  logic [31:0] core_dram_addr = '0, core_dram_wdata = '0, core_mem_paddr = '0;
  logic [31:0] core_data_wdata = '0;
  logic [2:0]  core_dram_ctrl = '0;
  logic        core_busy, core_done;
  logic [31:0] core_dram_odata, core_data_data;
  logic        arb_req;
  logic        arb_gnt = 1'b0;
  logic        arb_dram_le, arb_dram_we_t, arb_data_le, arb_data_we;
  logic [31:0] arb_dram_addr, arb_dram_wdata, arb_mem_paddr, arb_data_wdata;
  logic [2:0]  arb_dram_ctrl;
  logic        arb_sys_busy = 1'b0;
  logic [31:0] arb_dram_odata = '0, arb_data_data = '0;
  logic        err_timeout;

  logic [3:0]  arb_strb;
  assign arb_strb = {arb_dram_le, arb_dram_we_t, arb_data_le, arb_data_we};

  int tests = 0;
  int fails = 0;
  logic [64:0] exp_q[$];  // {err_timeout, core_dram_odata, core_data_data}

  bus_req_port #(.TMO_W(12)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .core_dram_le(core_dram_le), .core_dram_we_t(core_dram_we_t),
    .core_data_le(core_data_le), .core_data_we(core_data_we),
    .core_dram_addr(core_dram_addr), .core_dram_wdata(core_dram_wdata),
    .core_dram_ctrl(core_dram_ctrl), .core_mem_paddr(core_mem_paddr),
    .core_data_wdata(core_data_wdata),
    .core_busy(core_busy), .core_done(core_done),
    .core_dram_odata(core_dram_odata), .core_data_data(core_data_data),
    .arb_req(arb_req), .arb_gnt(arb_gnt),
    .arb_dram_le(arb_dram_le), .arb_dram_we_t(arb_dram_we_t),
    .arb_data_le(arb_data_le), .arb_data_we(arb_data_we),
    .arb_dram_addr(arb_dram_addr), .arb_dram_wdata(arb_dram_wdata),
    .arb_dram_ctrl(arb_dram_ctrl), .arb_mem_paddr(arb_mem_paddr),
    .arb_data_wdata(arb_data_wdata),
    .arb_sys_busy(arb_sys_busy),
    .arb_dram_odata(arb_dram_odata), .arb_data_data(arb_data_data),
    .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge CLK) begin
    if (RST_X && core_done) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got done with %h/%h, expected none",
                 core_dram_odata, core_data_data);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if ({err_timeout, core_dram_odata, core_data_data} !== e) begin
          fails++;
          $display("FAIL done_resp: got %h, expected %h",
                   {err_timeout, core_dram_odata, core_data_data}, e);
        end
      end
    end
  end

  // Called just after a negedge; returns at the next negedge with strobes dropped.
  task automatic strobe(input logic [3:0] s, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] ctrl, input logic [31:0] pa, input logic [31:0] dwd);
    {core_dram_le, core_dram_we_t, core_data_le, core_data_we} = s;
    core_dram_addr = addr; core_dram_wdata = wd; core_dram_ctrl = ctrl;
    core_mem_paddr = pa;   core_data_wdata = dwd;
    @(negedge CLK);
    {core_dram_le, core_dram_we_t, core_data_le, core_data_we} = 4'b0;
    // Scribble the fields so a missing latch shows up.
    core_dram_addr = ~addr; core_dram_wdata = ~wd; core_dram_ctrl = ~ctrl;
    core_mem_paddr = ~pa;   core_data_wdata = ~dwd;
  endtask

  // Called at a negedge where the arb strobes are visible (ISSUE state).
  task automatic finish_read(input logic [31:0] dv, input logic [31:0] ddv, input logic errv);
    arb_sys_busy = 1'b1;
    @(negedge CLK);
    check("strobe_drop", {60'd0, arb_strb}, 64'd0);
    arb_sys_busy = 1'b0;
    arb_dram_odata = dv;
    arb_data_data = ddv;
    exp_q.push_back({errv, dv, ddv});
    @(negedge CLK);
    check("done_latency", {63'd0, core_done}, 64'd1);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_ctl", {57'd0, core_busy, core_done, arb_req, arb_strb, err_timeout}, 64'd0);
    check("rst_data", {core_dram_odata, core_data_data}, 64'd0);
    RST_X = 1'b1;
    @(negedge CLK);

    // Basic read, grant already high: one-cycle strobe, done 4 cycles after strobe
    arb_gnt = 1'b1;
    strobe(4'b1000, 32'h8000_1000, 32'h0, 3'd2, 32'h0, 32'h0);
    check("t1_req_busy", {62'd0, arb_req, core_busy}, 64'd3);
    check("t1_no_strb_yet", {60'd0, arb_strb}, 64'd0);
    @(negedge CLK);
    check("t1_strb", {60'd0, arb_strb}, 64'h8);
    check("t1_addr", {29'd0, arb_dram_ctrl, arb_dram_addr}, {29'd0, 3'd2, 32'h8000_1000});
    finish_read(32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge CLK);
    check("t1_done_pulse", {62'd0, core_done, core_busy}, 64'd0);

    // Write held off by grant low for 10 cycles
    arb_gnt = 1'b0;
    strobe(4'b0001, 32'h0, 32'h0, 3'd0, 32'h1000_0000, 32'h41);
    for (int i = 0; i < 10; i++) begin
      check("t2_wait_gnt", {arb_req, arb_strb, arb_mem_paddr, arb_data_wdata[26:0]},
            {1'b1, 4'b0, 32'h1000_0000, 27'h41});
      @(negedge CLK);
    end
    arb_gnt = 1'b1;
    @(negedge CLK);
    check("t2_strb", {60'd0, arb_strb}, 64'h1);
    check("t2_fields", {arb_mem_paddr, arb_data_wdata}, {32'h1000_0000, 32'h41});
    finish_read(32'h0, 32'h0000_5555, 1'b0);

    // Second strobe while busy is ignored
    arb_gnt = 1'b0;
    strobe(4'b1000, 32'h100, 32'h0, 3'd0, 32'hAAAA_0000, 32'h0);
    strobe(4'b0010, 32'h300, 32'h0, 3'd0, 32'h200, 32'h0);
    check("t3_fields_kept", {arb_dram_addr, arb_mem_paddr}, {32'h100, 32'hAAAA_0000});
    arb_gnt = 1'b1;
    @(negedge CLK);
    check("t3_strb", {60'd0, arb_strb}, 64'h8);
    finish_read(32'h1111_2222, 32'h3333_4444, 1'b0);
    repeat (5) @(negedge CLK);

    // Two strobes together, then a back-to-back strobe in the done cycle
    strobe(4'b0110, 32'h2000, 32'h0, 3'd1, 32'h3000, 32'h0);
    @(negedge CLK);
    check("t4_strb_pair", {60'd0, arb_strb}, 64'h6);
    finish_read(32'hA5A5_0001, 32'h5A5A_0002, 1'b0);
    strobe(4'b1000, 32'h4000, 32'h0, 3'd0, 32'h0, 32'h0);
    check("t4_accept_on_done", {61'd0, core_done, arb_req, core_busy}, 64'd3);
    @(negedge CLK);
    check("t4_b2b_strb", {arb_dram_addr, 28'd0, arb_strb}, {32'h4000, 32'h8});
    finish_read(32'h0BAD_F00D, 32'h0, 1'b0);

    // Timeout: sys_busy never rises after grant
    arb_dram_odata = 32'hCAFE_CAFE;
    arb_data_data = 32'h1234;
    check("t5_err_clear", {63'd0, err_timeout}, 64'd0);
    exp_q.push_back({1'b1, 32'h0, 32'h0});
    strobe(4'b1000, 32'h500, 32'h0, 3'd0, 32'h0, 32'h0);
    n = 1;
    @(negedge CLK);
    n++;
    check("t5_strb_held", {60'd0, arb_strb}, 64'h8);
    while (!core_done && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    check("t5_tmo_cycles", 64'(n), 64'd4097);
    check("t5_tmo_state", {59'd0, err_timeout, arb_req, core_busy, arb_strb[3], arb_strb[1]},
          64'h10);
    @(negedge CLK);
    strobe(4'b1000, 32'h600, 32'h0, 3'd0, 32'h0, 32'h0);
    @(negedge CLK);
    check("t5_next_req", {60'd0, arb_strb}, 64'h8);
    finish_read(32'h0000_600D, 32'h0, 1'b1);

    // Asynchronous reset in WAIT_DONE
    strobe(4'b0010, 32'h700, 32'h77, 3'd5, 32'h800, 32'h88);
    @(negedge CLK);
    arb_sys_busy = 1'b1;
    repeat (2) @(negedge CLK);
    #2 RST_X = 1'b0;
    #1;
    check("t6_rst_ctl", {57'd0, core_busy, core_done, arb_req, arb_strb, err_timeout}, 64'd0);
    check("t6_rst_odata", {core_dram_odata, core_data_data}, 64'd0);
    check("t6_rst_fields", {arb_dram_addr, arb_mem_paddr}, 64'd0);
    check("t6_rst_wfields", {29'd0, arb_dram_ctrl, arb_data_wdata}, 64'd0);
    arb_sys_busy = 1'b0;
    @(negedge CLK);
    RST_X = 1'b1;
    @(negedge CLK);
    strobe(4'b1000, 32'h900, 32'h0, 3'd0, 32'h0, 32'h0);
    @(negedge CLK);
    check("t6_post_rst_strb", {60'd0, arb_strb}, 64'h8);
    finish_read(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);

    repeat (4) @(negedge CLK);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_req_port.md
BUS_REQ_PORT -- requirements
Module: bus_req_port

Interface
REQ-001 Parameter TMO_W, default 12: timeout counter width; timeout fires at count 2^TMO_W-1 (4095).
REQ-002 CLK  in  1  single clock, all state on rising edge.
REQ-003 RST_X  in  1  reset, asynchronous, active-low.
REQ-004 core_dram_le, core_dram_we_t, core_data_le, core_data_we  in  1 each  core request strobes, single-cycle pulses.
REQ-005 core_dram_addr  in  32; core_dram_wdata  in  32; core_dram_ctrl  in  3; core_mem_paddr  in  32; core_data_wdata  in  32  request fields, valid with a strobe.
REQ-006 core_busy  out  1  request in flight.
REQ-007 core_done  out  1  one-cycle completion pulse.
REQ-008 core_dram_odata  out  32; core_data_data  out  32  returned read data.
REQ-009 arb_req  out  1  bus request to arbiter; arb_gnt  in  1  grant for this port.
REQ-010 arb_dram_le, arb_dram_we_t, arb_data_le, arb_data_we  out  1 each  strobes toward arbiter.
REQ-011 arb_dram_addr  out  32; arb_dram_wdata  out  32; arb_dram_ctrl  out  3; arb_mem_paddr  out  32; arb_data_wdata  out  32  latched fields, stable from acceptance until return to IDLE.
REQ-012 arb_sys_busy  in  1  OR of dram busy, data busy, !tx_ready.
REQ-013 arb_dram_odata  in  32; arb_data_data  in  32  read data from arbiter.
REQ-014 err_timeout  out  1  sticky timeout flag.

Function
REQ-015 States: IDLE, REQ, ISSUE, WAIT_DONE; all outputs registered.
REQ-016 IDLE: any core strobe high -> latch all four strobe bits and all fields, core_busy=1, arb_req=1, go REQ next cycle.
REQ-017 Strobes are accepted only in IDLE; strobes in any other state are ignored, with no field update.
REQ-018 Multiple strobes in the same cycle are all latched and issued together as one transaction.
REQ-019 REQ: when arb_gnt=1, assert the arb_* strobes equal to the latched bits, clear the timeout counter, go ISSUE; otherwise wait indefinitely with no timeout.
REQ-020 ISSUE: hold strobes high until arb_sys_busy=1 is sampled; then clear all arb_* strobes and go WAIT_DONE.
REQ-021 WAIT_DONE: when arb_sys_busy=0, capture arb_dram_odata and arb_data_data into core_dram_odata and core_data_data (captured for writes as well), core_busy=0, arb_req=0, core_done=1 for one cycle, go IDLE.
REQ-022 Minimum latency from strobe to core_done = 4 cycles (gnt already high, busy rises in the first ISSUE cycle and falls in the next).
REQ-023 arb_req stays high from acceptance until return to IDLE; arb_gnt is sampled only in REQ.
REQ-024 Timeout counter increments every cycle in ISSUE and WAIT_DONE and saturates.
REQ-025 Timeout: counter reaching 2^TMO_W-1 -> err_timeout=1, strobes=0, arb_req=0, core_busy=0, core_done pulse, both data outputs =0, go IDLE.
REQ-026 err_timeout is cleared only by reset.
REQ-027 A strobe in the cycle core_done is high is accepted, because the state is IDLE in that cycle.

Reset
REQ-028 RST_X low asynchronously forces IDLE and zeroes every output, latched field and counter, including mid-transaction.
REQ-029 Recovery from reset needs no arbiter handshake; a pending arbiter transaction is abandoned.

Verification
REQ-030 core_dram_le pulse, addr=0x80001000, gnt=1, sys_busy high 1 cycle then odata=0xDEADBEEF -> arb_dram_le high exactly 1 cycle, core_done 4 cycles after strobe, core_dram_odata=0xDEADBEEF.
REQ-031 core_data_we with paddr=0x10000000, wdata=0x41 while gnt=0 for 10 cycles -> arb_req high, no arb strobe until gnt rises; arb_mem_paddr/arb_data_wdata stable throughout.
REQ-032 Second strobe while core_busy=1 -> ignored, latched fields unchanged, exactly one core_done.
REQ-033 sys_busy never rises after grant -> err_timeout=1 after 4095 cycles in ISSUE, core_done pulse, data outputs 0, port accepts the next request.
REQ-034 RST_X low during WAIT_DONE -> all outputs 0 immediately, without waiting for a clock edge; a normal read completes after release.
REQ-035 core_dram_we_t and core_data_le in the same cycle -> both arb strobes asserted together, single core_done.
